// File: rtl/image_window_gen.sv
// image_window_gen
//   Holds one IMG_W x IMG_W image of PIX_W-bit pixels and streams every
//   WIN x WIN window over a valid/ready handshake. Window origins are scanned
//   row by row, with Y (the column origin) as the inner loop.
//
// Ports
//   CLK, RST             clock; synchronous active-high reset
//   PIX_WE/ADDR/DATA     byte write port for the image; honoured only in IDLE
//   START                begin streaming the stored image (ignored unless IDLE)
//   BUSY                 high while windows are being streamed
//   WIN_VALID/WIN_READY  window handshake
//   X, Y                 window row / column origin
//   IMGIN                window pixels, IMGIN[(i*WIN+j)*PIX_W +: PIX_W] = pix[X+i][Y+j]
//   WIN_LAST             current window is the final one
//   FRAME_DONE           one-cycle pulse after the final window is accepted
//
// Build option
//   IMGWIN_BINARIZE_EN   when defined, pixels are stored as all-ones if
//                        PIX_DATA >= THRESH and as zero otherwise.
module image_window_gen #(
  parameter int IMG_W  = 28,
  parameter int WIN    = 5,
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PIX_WE,
  input  logic [9:0]               PIX_ADDR,
  input  logic [PIX_W-1:0]         PIX_DATA,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     WIN_VALID,
  input  logic                     WIN_READY,
  output logic [4:0]               X,
  output logic [4:0]               Y,
  output logic [WIN*WIN*PIX_W-1:0] IMGIN,
  output logic                     WIN_LAST,
  output logic                     FRAME_DONE
);

  localparam int NPIX = IMG_W * IMG_W;
  localparam int AW   = 10;
  localparam int NWIN = IMG_W - WIN + 1;
  localparam int CW   = 5;
  localparam int MAXC = NWIN - 1;
  localparam int WINB = WIN * WIN * PIX_W;

`ifdef IMGWIN_BINARIZE_EN
  localparam bit BINARIZE = 1'b1;
`else
  localparam bit BINARIZE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FIN} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     x_reg, x_next, y_reg, y_next;
  logic              last_reg, last_next;
  logic              done_reg, done_next;
  logic [WINB-1:0]   imgin_reg, imgin_next;

  logic [PIX_W-1:0]  mem [NPIX];
  logic              wr_ok;
  logic [PIX_W-1:0]  wr_val;
  logic [CW-1:0]     sel_x, sel_y;
  logic [WINB-1:0]   win_bus;

  assign wr_ok  = (state_reg == S_IDLE) && PIX_WE && (PIX_ADDR < AW'(NPIX));
  assign wr_val = BINARIZE ? ((PIX_DATA >= PIX_W'(THRESH)) ? '1 : '0) : PIX_DATA;

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[PIX_ADDR] <= wr_val;
    end
  end

  // Origin of the window that will be loaded at the next edge: (0,0) when
  // starting, otherwise the successor of the current origin. Clamped to (0,0)
  // on the last window so the taps never index past the image.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    if (state_reg == S_STREAM && !last_reg) begin
      if (y_reg == CW'(MAXC)) begin
        sel_x = x_reg + CW'(1);
        sel_y = '0;
      end else begin
        sel_x = x_reg;
        sel_y = y_reg + CW'(1);
      end
    end
  end

  // Window taps. A write landing in the same cycle as START is forwarded so
  // that the first window already sees it.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_row
    for (genvar gj = 0; gj < WIN; gj++) begin : g_col
      logic [AW-1:0] tap;
      assign tap = (AW'(sel_x) + AW'(gi)) * AW'(IMG_W) + AW'(sel_y) + AW'(gj);
      assign win_bus[(gi*WIN+gj)*PIX_W +: PIX_W] =
        (wr_ok && (PIX_ADDR == tap)) ? wr_val : mem[tap];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      imgin_reg <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      imgin_reg <= imgin_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    imgin_next = imgin_reg;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          state_next = S_STREAM;
          x_next     = sel_x;
          y_next     = sel_y;
          last_next  = (sel_x == CW'(MAXC)) && (sel_y == CW'(MAXC));
          imgin_next = win_bus;
        end
      end
      S_STREAM: begin
        // WIN_VALID is implied by this state, so READY alone is the handshake.
        if (WIN_READY) begin
          if (last_reg) begin
            state_next = S_FIN;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            x_next     = sel_x;
            y_next     = sel_y;
            last_next  = (sel_x == CW'(MAXC)) && (sel_y == CW'(MAXC));
            imgin_next = win_bus;
          end
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
        x_next     = '0;
        y_next     = '0;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign BUSY       = (state_reg == S_STREAM);
  assign WIN_VALID  = (state_reg == S_STREAM);
  assign X          = x_reg;
  assign Y          = y_reg;
  assign IMGIN      = imgin_reg;
  assign WIN_LAST   = last_reg;
  assign FRAME_DONE = done_reg;

endmodule

// File: tb/tb_image_window_gen.sv
// Randomized bench for image_window_gen. A pixel array model plus a window
// index (k -> origin k/24, k%24) gives the expected output for every cycle.
module tb_image_window_gen;

  localparam int IMG  = 28;
  localparam int NWIN = 24;
  localparam int NW   = NWIN * NWIN;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         PIX_WE = 1'b0;
  logic [9:0]   PIX_ADDR = '0;
  logic [7:0]   PIX_DATA = '0;
  logic         START = 1'b0;
  logic         BUSY;
  logic         WIN_VALID;
  logic         WIN_READY = 1'b0;
  logic [4:0]   X;
  logic [4:0]   Y;
  logic [199:0] IMGIN;
  logic         WIN_LAST;
  logic         FRAME_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   model_pix [IMG*IMG];
  logic [199:0] first_win;
  logic [199:0] last_win;

  image_window_gen dut (
    .CLK(CLK), .RST(RST), .PIX_WE(PIX_WE), .PIX_ADDR(PIX_ADDR),
    .PIX_DATA(PIX_DATA), .START(START), .BUSY(BUSY), .WIN_VALID(WIN_VALID),
    .WIN_READY(WIN_READY), .X(X), .Y(Y), .IMGIN(IMGIN), .WIN_LAST(WIN_LAST),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stored_val(input logic [7:0] d);
`ifdef IMGWIN_BINARIZE_EN
    return (d >= 8'd128) ? 8'hFF : 8'h00;
`else
    return d;
`endif
  endfunction

  function automatic logic [199:0] exp_win(input int x, input int y);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = model_pix[(x+i)*IMG + (y+j)];
    return w;
  endfunction

  // Called at a negedge while the DUT is idle.
  task automatic pix_write(input int addr, input logic [7:0] data);
    PIX_WE   = 1'b1;
    PIX_ADDR = 10'(addr);
    PIX_DATA = data;
    if (addr < IMG*IMG) model_pix[addr] = stored_val(data);
    @(negedge CLK);
    PIX_WE = 1'b0;
  endtask

  // mode 0: READY always 1; 1: READY toggles 1/0; 2: random READY, START
  // pokes and an ignored pixel write during the stream.
  // Returns early (window max_hs on the outputs) when max_hs < NW.
  task automatic run_frame(input int mode, input int max_hs, output int cycles);
    int  k;
    int  cyc;
    bit  rdy;
    k   = 0;
    cyc = 0;
    START = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
    PIX_WE = 1'b0;
    while (k < max_hs && cyc < 4000) begin
      check("valid",  256'(WIN_VALID), 256'(1));
      check("busy",   256'(BUSY), 256'(1));
      check("done_in_stream", 256'(FRAME_DONE), 256'(0));
      check("x",      256'(X), 256'(k / NWIN));
      check("y",      256'(Y), 256'(k % NWIN));
      check("last",   256'(WIN_LAST), 256'(k == NW - 1));
      check("imgin",  256'(IMGIN), 256'(exp_win(k / NWIN, k % NWIN)));
      if (k == 0) first_win = IMGIN;
      if (k == NW - 1) last_win = IMGIN;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      WIN_READY = rdy;
      if (mode == 2) begin
        START = ($urandom_range(0, 15) == 0);
        if (cyc == 7) begin
          PIX_WE   = 1'b1;
          PIX_ADDR = 10'd0;
          PIX_DATA = 8'hAA;
        end
      end
      @(negedge CLK);
      START  = 1'b0;
      PIX_WE = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    cycles = cyc;
    if (max_hs < NW) begin
      check("partial_cnt", 256'(k), 256'(max_hs));
      return;
    end
    WIN_READY = 1'b0;
    check("frame_cnt", 256'(k), 256'(NW));
    check("fin_valid", 256'(WIN_VALID), 256'(0));
    check("fin_busy",  256'(BUSY), 256'(0));
    check("fin_done",  256'(FRAME_DONE), 256'(1));
    if (mode == 2) START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("idle_done", 256'(FRAME_DONE), 256'(0));
    check("idle_busy", 256'(BUSY), 256'(0));
    check("idle_x",    256'(X), 256'(0));
    check("idle_y",    256'(Y), 256'(0));
    @(negedge CLK);
    check("idle2_busy", 256'(BUSY), 256'(0));
    check("idle2_done", 256'(FRAME_DONE), 256'(0));
  endtask

  initial begin
    int cyc;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_busy",  256'(BUSY), 256'(0));
    check("rst_valid", 256'(WIN_VALID), 256'(0));
    check("rst_last",  256'(WIN_LAST), 256'(0));
    check("rst_done",  256'(FRAME_DONE), 256'(0));
    check("rst_x",     256'(X), 256'(0));
    check("rst_y",     256'(Y), 256'(0));
    check("rst_imgin", 256'(IMGIN), 256'(0));
    RST = 1'b0;
    @(negedge CLK);

    // Ramp image, full-rate frame.
    for (int a = 0; a < IMG*IMG; a++) pix_write(a, 8'(a));
    run_frame(0, NW, cyc);
    check("full_rate_cycles", 256'(cyc), 256'(NW));
`ifndef IMGWIN_BINARIZE_EN
    check("ramp_w00_b0",  256'(first_win[7:0]),     256'(8'h00));
    check("ramp_w00_b5",  256'(first_win[47:40]),   256'(8'h1C));
    check("ramp_w00_b24", 256'(first_win[199:192]), 256'(8'h74));
    check("ramp_wlast_b0",  256'(last_win[7:0]),     256'(8'h9B));
    check("ramp_wlast_b24", 256'(last_win[199:192]), 256'(8'h0F));
`endif

    // READY toggling: one handshake every other cycle.
    run_frame(1, NW, cyc);
    check("toggle_cycles", 256'(cyc), 256'(2*NW - 1));

    // Random READY, START pokes, write during stream (model untouched).
    run_frame(2, NW, cyc);
    pix_write(800, 8'h55);
    run_frame(0, NW, cyc);
    check("stream_write_ignored", 256'(first_win[7:0]), 256'(model_pix[0]));

    // Reset while stalled at window (10,5).
    run_frame(0, 10*NWIN + 5, cyc);
    WIN_READY = 1'b0;
    @(negedge CLK);
    check("stall_x", 256'(X), 256'(10));
    check("stall_y", 256'(Y), 256'(5));
    check("stall_imgin", 256'(IMGIN), 256'(exp_win(10, 5)));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mrst_valid", 256'(WIN_VALID), 256'(0));
    check("mrst_busy",  256'(BUSY), 256'(0));
    check("mrst_x",     256'(X), 256'(0));
    check("mrst_y",     256'(Y), 256'(0));
    check("mrst_imgin", 256'(IMGIN), 256'(0));
    check("mrst_done",  256'(FRAME_DONE), 256'(0));
    @(negedge CLK);
    check("mrst_done2", 256'(FRAME_DONE), 256'(0));
    run_frame(0, NW, cyc);

    // Write coinciding with START must be visible in window (0,0).
    PIX_WE   = 1'b1;
    PIX_ADDR = 10'd29;
    PIX_DATA = 8'($urandom);
    model_pix[29] = stored_val(PIX_DATA);
    run_frame(0, NW, cyc);
    check("start_write_fwd", 256'(first_win[55:48]), 256'(model_pix[29]));

    // Random image, random handshake.
    for (int a = 0; a < IMG*IMG; a++) pix_write(a, 8'($urandom));
    run_frame(2, NW, cyc);

    // Threshold edge values.
    pix_write(0, 8'h7F);
    pix_write(1, 8'h80);
    run_frame(0, NW, cyc);
`ifdef IMGWIN_BINARIZE_EN
    check("binarize", 256'(first_win[15:0]), 256'(16'hFF00));
`else
    check("raw_store", 256'(first_win[15:0]), 256'(16'h807F));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
